lfsr_checker: RTL and testbench

- Receive-side partner of the 32-bit LFSR sequence generator: consumes the serial out_bit stream and self-synchronises to it.
- Verifies lock, then counts bit errors against a locally predicted sequence, declaring loss of sync on excessive errors.
- Sits at the far end of a link or loopback under test, driven by the same enable qualifier as the generator.

---
 rtl/lfsr_checker.sv | 177 +++++++++++++++++
 tb/tb_lfsr_checker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side partner of the 32-bit LFSR generator.
// Self-synchronises to the serial stream (HUNT -> VERIFY -> LOCKED), then
// flywheels the local prediction and counts bit errors against it.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous active-low reset
//   enable     qualifies in_bit; bit consumed only when enable=1
//   in_bit     received serial bit
//   clear_err  synchronous clear of err_count (independent of enable)
//   locked     high while in LOCKED
//   err_pulse  one-cycle pulse per mismatch detected while LOCKED
//   sync_lost  one-cycle pulse on LOCKED -> HUNT
//   err_count  saturating mismatch count
//   exp_seq    history/prediction register
module lfsr_checker #(
  parameter logic [31:0] TAPS        = 32'h8020_0003,
  parameter int unsigned VERIFY_LEN  = 64,
  parameter int unsigned WINDOW      = 256,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_bit,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic             sync_lost,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      exp_seq
);

  localparam int unsigned VC_W = $clog2(VERIFY_LEN);
  localparam int unsigned WC_W = $clog2(WINDOW);
  localparam int unsigned WE_W = $clog2(LOSS_THRESH + 1);

  localparam logic [VC_W-1:0] VC_LAST   = VC_W'(VERIFY_LEN - 1);
  localparam logic [WC_W-1:0] WC_LAST   = WC_W'(WINDOW - 1);
  localparam logic [WE_W-1:0] WE_LIM    = WE_W'(LOSS_THRESH);
  localparam logic [5:0]      FILL_FULL = 6'd32;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t           r_state, w_state_n;
  logic [31:0]      r_h, w_h_n;
  logic [5:0]       r_fill, w_fill_n;
  logic [VC_W-1:0]  r_vcnt, w_vcnt_n;
  logic [WC_W-1:0]  r_win_cnt, w_win_cnt_n;
  logic [WE_W-1:0]  r_win_err, w_win_err_n;
  logic             r_locked, w_locked_n;
  logic             r_err_pulse, w_err_pulse_n;
  logic             r_sync_lost, w_sync_lost_n;
  logic [ERR_W-1:0] r_err_count, w_err_count_n;

  logic             w_pred;
  logic             w_mis;
  logic             w_hit;
  logic [WE_W-1:0]  w_win_err_inc;
  logic [ERR_W-1:0] w_err_base;

  assign w_pred        = ^(r_h & TAPS);
  assign w_mis         = in_bit ^ w_pred;
  assign w_win_err_inc = r_win_err + WE_W'(w_mis);

  always_comb begin
    w_state_n     = r_state;
    w_h_n         = r_h;
    w_fill_n      = r_fill;
    w_vcnt_n      = r_vcnt;
    w_win_cnt_n   = r_win_cnt;
    w_win_err_n   = r_win_err;
    w_err_pulse_n = 1'b0;
    w_sync_lost_n = 1'b0;
    w_hit         = 1'b0;

    if (enable) begin
      case (r_state)
        HUNT: begin
          w_h_n    = {r_h[30:0], in_bit};
          w_fill_n = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 6'd1;
          // All-zero history is the LFSR lockup state; stay hunting.
          if (w_fill_n == FILL_FULL && w_h_n != '0) begin
            w_state_n = VERIFY;
            w_vcnt_n  = '0;
          end
        end
        VERIFY: begin
          w_h_n = {r_h[30:0], in_bit};
          if (!w_mis) begin
            if (r_vcnt == VC_LAST) begin
              w_state_n   = LOCKED;
              w_win_cnt_n = '0;
              w_win_err_n = '0;
            end else begin
              w_vcnt_n = r_vcnt + VC_W'(1);
            end
          end else begin
            w_state_n = HUNT;
            w_fill_n  = '0;
            w_vcnt_n  = '0;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction, not the received bit, enters history.
          w_h_n = {r_h[30:0], w_pred};
          if (w_mis) begin
            w_err_pulse_n = 1'b1;
            w_hit         = 1'b1;
          end
          // Threshold uses the count including this bit, ahead of the
          // end-of-window clear.
          if (w_win_err_inc == WE_LIM) begin
            w_state_n     = HUNT;
            w_sync_lost_n = 1'b1;
            w_fill_n      = '0;
            w_vcnt_n      = '0;
            w_win_cnt_n   = '0;
            w_win_err_n   = '0;
          end else if (r_win_cnt == WC_LAST) begin
            w_win_cnt_n = '0;
            w_win_err_n = '0;
          end else begin
            w_win_cnt_n = r_win_cnt + WC_W'(1);
            w_win_err_n = w_win_err_inc;
          end
        end
        default: begin
          w_state_n = HUNT;
          w_fill_n  = '0;
          w_vcnt_n  = '0;
        end
      endcase
    end

    w_err_base    = clear_err ? '0 : r_err_count;
    w_err_count_n = w_err_base;
    if (w_hit && w_err_base != '1)
      w_err_count_n = w_err_base + ERR_W'(1);

    w_locked_n = (w_state_n == LOCKED);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= HUNT;
      r_h         <= '0;
      r_fill      <= '0;
      r_vcnt      <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_sync_lost <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_n;
      r_h         <= w_h_n;
      r_fill      <= w_fill_n;
      r_vcnt      <= w_vcnt_n;
      r_win_cnt   <= w_win_cnt_n;
      r_win_err   <= w_win_err_n;
      r_locked    <= w_locked_n;
      r_err_pulse <= w_err_pulse_n;
      r_sync_lost <= w_sync_lost_n;
      r_err_count <= w_err_count_n;
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign sync_lost = r_sync_lost;
  assign err_count = r_err_count;
  assign exp_seq   = r_h;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: a reference generator feeds the
// checker; per-cycle expectations are queued when stimulus is driven and
// compared one edge later.
module tb_lfsr_checker;

  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        in_bit = 1'b0;
  logic        clear_err = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic        sync_lost;
  logic [15:0] err_count;
  logic [31:0] exp_seq;

  lfsr_checker #(
    .TAPS(TAPS), .VERIFY_LEN(64), .WINDOW(256), .LOSS_THRESH(8), .ERR_W(16)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .in_bit(in_bit),
    .clear_err(clear_err), .locked(locked), .err_pulse(err_pulse),
    .sync_lost(sync_lost), .err_count(err_count), .exp_seq(exp_seq)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       nm;
    logic        lk, ep, sl;
    logic [15:0] ec;
    bit          chk_h;
    logic [31:0] h;
  } exp_t;

  typedef struct {
    logic        rst_n, en, b, clr;
    logic        lk;
    logic [31:0] h;
  } vec_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] g;     // reference generator state
  logic [31:0] hist;  // last 32 true generator bits

  task automatic cyc(input logic rst_n, en, b, clr, input string nm,
                     input logic lk, ep, sl, input logic [15:0] ec,
                     input bit chk_h, input logic [31:0] h);
    exp_t e;
    reset = rst_n; enable = en; in_bit = b; clear_err = clr;
    e.nm = nm; e.lk = lk; e.ep = ep; e.sl = sl; e.ec = ec;
    e.chk_h = chk_h; e.h = h;
    exp_q.push_back(e);
    @(posedge clock); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (locked !== e.lk || err_pulse !== e.ep || sync_lost !== e.sl ||
          err_count !== e.ec || (e.chk_h && exp_seq !== e.h)) begin
        errors++;
        $display("FAIL %s: got lk=%b ep=%b sl=%b ec=%0d h=%h, want lk=%b ep=%b sl=%b ec=%0d h=%h",
                 e.nm, locked, err_pulse, sync_lost, err_count, exp_seq,
                 e.lk, e.ep, e.sl, e.ec, e.chk_h ? e.h : exp_seq);
      end
    end
  endtask

  // One cycle of generator-driven stimulus; flip inverts the transmitted bit.
  task automatic gstep(input logic en, flip, clr, input string nm,
                       input logic lk, ep, sl, input logic [15:0] ec);
    logic t, b;
    if (en) begin
      t    = g[31];
      g    = {g[30:0], ^(g & TAPS)};
      hist = {hist[30:0], t};
      b    = t ^ flip;
    end else begin
      b = logic'($urandom_range(0, 1));
    end
    cyc(1'b1, en, b, clr, nm, lk, ep, sl, ec, 1'b1, hist);
  endtask

  task automatic do_reset(input string nm);
    cyc(1'b0, 1'b1, logic'($urandom_range(0, 1)), 1'b0, nm,
        1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 32'h0);
    hist = '0;
  endtask

  vec_t        tbl[7];
  logic [15:0] ec;
  logic [31:0] rh;
  int          n;
  logic        en, fl;

  initial begin
    // rst_n en b clr | locked exp_seq
    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h5};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hB};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};

    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 7; i++)
      cyc(tbl[i].rst_n, tbl[i].en, tbl[i].b, tbl[i].clr, $sformatf("tbl%0d", i),
          tbl[i].lk, 1'b0, 1'b0, 16'd0, 1'b1, tbl[i].h);

    // Test 1: clean stream from seed 1; lock on the 96th valid bit.
    do_reset("t1_reset");
    g = 32'h1;
    for (int k = 1; k <= 96 + 500; k++)
      gstep(1'b1, 1'b0, 1'b0, "t1_clean", logic'(k >= 96), 1'b0, 1'b0, 16'd0);

    // Test 2: single error at locked bit 501, then quiet for 200 bits.
    gstep(1'b1, 1'b1, 1'b0, "t2_err", 1'b1, 1'b1, 1'b0, 16'd1);
    for (int k = 0; k < 200; k++)
      gstep(1'b1, 1'b0, 1'b0, "t2_quiet", 1'b1, 1'b0, 1'b0, 16'd1);

    // Advance to the window boundary at locked bit 768, clearing err_count.
    gstep(1'b1, 1'b0, 1'b1, "t3_clear", 1'b1, 1'b0, 1'b0, 16'd0);
    for (int k = 0; k < 66; k++)
      gstep(1'b1, 1'b0, 1'b0, "t3_gap", 1'b1, 1'b0, 1'b0, 16'd0);

    // Test 3: 8 errors within 85 bits of one window -> loss, then relock.
    ec = 16'd0;
    for (int i = 0; i <= 84 + 96; i++) begin
      fl = (i % 12 == 0) && (i <= 84);
      if (fl) ec++;
      gstep(1'b1, fl, 1'b0, "t3_loss",
            logic'(i < 84 || i >= 84 + 96), fl, logic'(i == 84), ec);
    end

    // Window boundary: 7 errors end window 1, 8th lands in window 2.
    for (int k = 1; k <= 300; k++) begin
      fl = (k >= 250) && (k <= 257);
      if (fl) ec++;
      gstep(1'b1, fl, 1'b0, "t3_window", 1'b1, fl, 1'b0, ec);
    end

    // Test 4: enable pattern 2 valid / 1 idle through fill and verify.
    do_reset("t4_reset");
    g = 32'h1;
    n = 0;
    for (int c = 0; n < 100; c++) begin
      en = (c % 3 != 2);
      if (en) n++;
      gstep(en, 1'b0, 1'b0, "t4_gapped", logic'(n >= 96), 1'b0, 1'b0, 16'd0);
    end
    for (int c = 0; c < 20; c++)
      gstep(1'b0, 1'b0, 1'b0, "t4_idle", 1'b1, 1'b0, 1'b0, 16'd0);
    for (int c = 0; c < 10; c++)
      gstep(1'b1, 1'b0, 1'b0, "t4_resume", 1'b1, 1'b0, 1'b0, 16'd0);

    // Test 5: stuck-at-0 never leaves HUNT; stuck-at-1 never verifies.
    do_reset("t5_reset");
    for (int k = 0; k < 300; k++)
      cyc(1'b1, 1'b1, 1'b0, 1'b0, "t5_stuck0", 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 32'h0);
    rh = '0;
    for (int k = 0; k < 200; k++) begin
      rh = {rh[30:0], 1'b1};
      cyc(1'b1, 1'b1, 1'b1, 1'b0, "t5_stuck1", 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, rh);
    end

    // Test 6: clear_err with a coincident mismatch; reset mid-lock.
    do_reset("t6_reset");
    g = 32'h1;
    for (int k = 1; k <= 96; k++)
      gstep(1'b1, 1'b0, 1'b0, "t6_lock", logic'(k >= 96), 1'b0, 1'b0, 16'd0);
    gstep(1'b1, 1'b1, 1'b0, "t6_err", 1'b1, 1'b1, 1'b0, 16'd1);
    gstep(1'b1, 1'b1, 1'b1, "t6_clr_hit", 1'b1, 1'b1, 1'b0, 16'd1);
    gstep(1'b0, 1'b0, 1'b1, "t6_clr_idle", 1'b1, 1'b0, 1'b0, 16'd0);
    gstep(1'b1, 1'b1, 1'b0, "t6_err2", 1'b1, 1'b1, 1'b0, 16'd1);
    for (int k = 0; k < 5; k++)
      gstep(1'b1, 1'b0, 1'b0, "t6_clean", 1'b1, 1'b0, 1'b0, 16'd1);
    do_reset("t6_midlock_reset");
    for (int k = 1; k <= 100; k++)
      gstep(1'b1, 1'b0, 1'b0, "t6_relock", logic'(k >= 96), 1'b0, 1'b0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
